// File: rtl/bcd_to_binary_if.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_binary_if
//  Brief    : Start/busy/done handshake bundle for the BCD-to-binary converter.
//  Revision : 1.0
// ============================================================================
interface bcd_to_binary_if #(
    parameter int DIGITS = 8,
    parameter int BIN_W  = 32
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  bin_out,
        input  err
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output bin_out,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_to_binary.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_binary
//  Brief    : Converts packed BCD to unsigned binary, one digit per clock, MSD first.
//  Revision : 1.0
// ============================================================================
module bcd_to_binary #(
    parameter int DIGITS = 8,
    parameter int BIN_W  = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    bcd_to_binary_if.slave     bus
);
    localparam int IN_W  = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 1);

    localparam logic [0:0]       S_IDLE = 1'b0;
    localparam logic [0:0]       S_CONV = 1'b1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIGITS - 1);

    logic [0:0]       state_q,   state_d;
    logic [IN_W-1:0]  sreg_q,    sreg_d;
    logic [BIN_W-1:0] acc_q,     acc_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             err_acc_q, err_acc_d;
    logic             done_q,    done_d;
    logic [BIN_W-1:0] bin_q,     bin_d;
    logic             err_q,     err_d;

    logic [3:0]       w_digit;
    logic [BIN_W-1:0] w_acc_step;
    logic             w_err_step;
    logic             w_last;

    assign w_digit    = sreg_q[IN_W-1 -: 4];
    assign w_acc_step = (acc_q << 3) + (acc_q << 1) + BIN_W'(w_digit);
    assign w_err_step = err_acc_q | (w_digit > 4'd9);
    assign w_last     = (cnt_q == C_LAST);

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sreg_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            err_acc_q <= 1'b0;
            done_q    <= 1'b0;
            bin_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            err_acc_q <= err_acc_d;
            done_q    <= done_d;
            bin_q     <= bin_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_CONV;
            S_CONV:  if (w_last)    state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sreg_d    = sreg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        err_acc_d = err_acc_q;
        done_d    = 1'b0;
        bin_d     = bin_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sreg_d    = bus.bcd_in;
                    acc_d     = '0;
                    cnt_d     = '0;
                    err_acc_d = 1'b0;
                end
            end
            S_CONV: begin
                sreg_d    = sreg_q << 4;
                acc_d     = w_acc_step;
                cnt_d     = cnt_q + 1'b1;
                err_acc_d = w_err_step;
                if (w_last) begin
                    done_d = 1'b1;
                    err_d  = w_err_step;
                    // A bad nibble makes the value meaningless, so publish zero.
                    bin_d  = w_err_step ? '0 : w_acc_step;
                end
            end
            default: ;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy    = (state_q == S_CONV);
        bus.done    = done_q;
        bus.bin_out = bin_q;
        bus.err     = err_q;
    end
endmodule
`default_nettype wire
